scm_mp_mem: RTL and testbench
=============================

// Module: scm_mp_mem
// PURPOSE
//  Parametrised multi-read-port standard-cell memory (SCM); successor to the single-port 65nm SCM macro.
//  Flop rows with per-row clock gating, 1 write port with byte enables, NR independent registered read ports.
//  Used as register-file/buffer replacement for small SRAMs. Gate-level/SDF back-annotated flow is unchanged.
// PARAMETERS
//  DATA_WIDTH  64  bits per row; must be a multiple of 8
//  ADDR_WIDTH  6   address bits
//  NUM_ROWS    64  implemented rows, 1..2**ADDR_WIDTH (non-power-of-2 allowed)
//  NUM_RD      2   number of read ports, 1..4
// PORTS
//  CLK    in   1              clock, all state on rising edge
//  RST    in   1              asynchronous, active-high reset
//  SE     in   1              scan/test enable for row clock gates
//  WE     in   1              write enable
//  WADDR  in   ADDR_WIDTH     write address
//  WBE    in   DATA_WIDTH/8   byte write enables (bit i -> DIN[8i+7:8i])
//  DIN    in   DATA_WIDTH     write data
//  RE     in   NUM_RD         per-port read enable
//  RADDR  in   NUM_RD*ADDR_WIDTH  port p address at [p*AW +: AW]
//  DOUT   out  NUM_RD*DATA_WIDTH  port p data at [p*DW +: DW]
//  DVALID out  NUM_RD         port p DOUT holds fresh data from last-cycle read
// BEHAVIOUR
//  - Reset: DOUT=0, DVALID=0 for all ports, async assert, sync-safe deassert. Array rows NOT reset.
//  - Write: edge k with WE=1, WADDR<NUM_ROWS: row[WADDR] bytes with WBE=1 take DIN; others hold.
//    WE=1 with WBE=0 is a no-op; WADDR>=NUM_ROWS is ignored (no row written).
//  - Row clock gate enable = (WE & WADDR==row & |WBE) | SE. SE=1 opens gates; row D inputs recirculate
//    unless written, so SE has no functional effect on contents.
//  - Read: edge k with RE[p]=1: DOUT[p] <= row[RADDR[p]]; DVALID[p] <= 1. Latency 1 cycle; data
//    stable from edge k until next read on that port. RE[p]=0: DOUT[p] holds, DVALID[p] <= 0.
//  - RADDR[p]>=NUM_ROWS with RE[p]=1: DOUT[p] <= 0, DVALID[p] <= 1.
//  - Ports independent; any ports may read the same address in the same cycle, identical data.
//  - Same-cycle read and write to same row: read-before-write, DOUT gets old row value (unless bypass).
//  - Reset mid-operation: in-flight read lost (DVALID=0); writes on the reset-asserted edge are dropped.
//  - No FSM; state = array + NUM_RD output regs + DVALID regs.
// CONFIGURATION
//  SCM_WR_BYPASS_EN defined: same-cycle same-address read returns merged data: bytes with WBE=1 from
//    DIN, others from old row (write-through). Applies per port.
//  Undefined: strict read-before-write as above; no DIN->DOUT path (shorter timing).
// STRUCTURE
//  - Package scm_pkg: BYTE_W=8 constant, num_bytes(DW) function, byte-merge function
//    merge(old,new,be), addr-range check function.
//  - Sub-module scm_row: one row = ICG (enable, SE) + DATA_WIDTH flops with byte-enable D-mux;
//    generated NUM_ROWS times. Read muxes and output regs in top.
// TESTING (DATA_WIDTH=64, ADDR_WIDTH=6, NUM_ROWS=48, NUM_RD=2, TCLK=10)
//  1 Reset: RST=1 at t=0..25 with RE=2'b11 -> DOUT=0, DVALID=0 throughout; released -> first read valid 1 cycle later.
//  2 Fill rows 0..47 with random DIN, WBE=8'hFF; read all rows on both ports, random order -> every DOUT
//    matches scoreboard, DVALID=1 one cycle after each RE.
//  3 Row 5=64'h1111_2222_3333_4444; write DIN=64'hAAAA_BBBB_CCCC_DDDD WBE=8'h0F -> read 5 = 64'h1111_2222_CCCC_DDDD.
//  4 Same-cycle WE to row 9 (old 64'h0, DIN 64'hFFFF...F, WBE=FF) and RE[0] row 9 -> DOUT0=0 without macro,
//    =64'hFFFF_FFFF_FFFF_FFFF with SCM_WR_BYPASS_EN; next read returns all-ones in both builds.
//  5 Out-of-range: write WADDR=50 DIN=64'h5A5A... -> rows 0..47 unchanged; read RADDR=50 -> DOUT=0, DVALID=1.
//  6 SE=1 for 20 cycles with WE=0 and random DIN -> all rows unchanged; RST pulse mid-read -> DVALID drops same cycle.

Source files
------------

// File: rtl/scm_mp_mem_pkg.sv
// -----------------------------------------------------------------------------
// scm_pkg : shared constants and helpers for the multi-read-port SCM.
//
// Contents
//   BYTE_W         width of one write-enable lane
//   MAX_DW/MAX_NB  widest row the helpers handle; callers zero-extend into
//                  these widths and truncate the result back
//   num_bytes()    byte lanes in a row of a given width
//   merge()        byte-wise merge of new data over an old word
//   addr_in_range()address lies inside the implemented rows
// -----------------------------------------------------------------------------
package scm_pkg;

    localparam int BYTE_W = 8;
    localparam int MAX_DW = 512;
    localparam int MAX_NB = MAX_DW / BYTE_W;

    function automatic int num_bytes(input int dw);
        return dw / BYTE_W;
    endfunction

    // Lanes with be=1 take new_word, all others keep old_word.
    function automatic logic [MAX_DW-1:0] merge(
        input logic [MAX_DW-1:0] old_word,
        input logic [MAX_DW-1:0] new_word,
        input logic [MAX_NB-1:0] be
    );
        logic [MAX_DW-1:0] m;
        m = old_word;
        for (int i = 0; i < MAX_NB; i++) begin
            if (be[i]) begin
                m[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
            end
        end
        return m;
    endfunction

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned rows);
        return addr < rows;
    endfunction

endpackage

// File: rtl/scm_mp_mem_if.sv
// -----------------------------------------------------------------------------
// scm_mp_mem_if : write/read bus of the multi-read-port SCM.
//
// Signals
//   se      scan/test enable forcing all row clock gates open
//   we      write enable
//   waddr   write address
//   wbe     byte write enables (bit i -> din[8i+7:8i])
//   din     write data
//   re      per-port read enable
//   raddr   port p address at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   dout    port p data at [p*DATA_WIDTH +: DATA_WIDTH]
//   dvalid  port p dout was loaded by a read on the previous edge
// Modports: master drives the requests, slave (the memory) drives the data.
// Parameters must match those of the scm_mp_mem instance it connects to.
// -----------------------------------------------------------------------------
interface scm_mp_mem_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_RD     = 2
) ();

    logic                         se;
    logic                         we;
    logic [ADDR_WIDTH-1:0]        waddr;
    logic [DATA_WIDTH/8-1:0]      wbe;
    logic [DATA_WIDTH-1:0]        din;
    logic [NUM_RD-1:0]            re;
    logic [NUM_RD*ADDR_WIDTH-1:0] raddr;
    logic [NUM_RD*DATA_WIDTH-1:0] dout;
    logic [NUM_RD-1:0]            dvalid;

    modport master (
        output se, we, waddr, wbe, din, re, raddr,
        input  dout, dvalid
    );

    modport slave (
        input  se, we, waddr, wbe, din, re, raddr,
        output dout, dvalid
    );

endinterface

// File: rtl/scm_mp_mem_row.sv
// -----------------------------------------------------------------------------
// scm_row : one storage row of the SCM.
//
// The row flops only load when the row clock gate is open. The gate is
// written as a load enable, which the standard-cell flow maps onto an
// integrated clock-gating cell. When open, each byte lane either takes din
// (write enabled and its wbe bit set) or recirculates its own value, so an
// open gate caused by se alone never changes the contents.
// Rows are deliberately not reset.
//
// Ports
//   clk    clock
//   se     scan/test enable, forces the gate open
//   wr_en  this row is the write target this cycle
//   wbe    byte write enables
//   din    write data
//   q      row contents
// -----------------------------------------------------------------------------
module scm_row
    import scm_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         se,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH/BYTE_W-1:0] wbe,
    input  logic [DATA_WIDTH-1:0]        din,
    output logic [DATA_WIDTH-1:0]        q
);

    localparam int NB = num_bytes(DATA_WIDTH);

    logic [NB-1:0]         be_eff;
    logic                  gate_en;
    logic [DATA_WIDTH-1:0] d;

    assign be_eff  = wr_en ? wbe : '0;
    // A write with no byte enabled leaves the gate closed.
    assign gate_en = (wr_en & (|wbe)) | se;
    assign d       = DATA_WIDTH'(merge(MAX_DW'(q), MAX_DW'(din), MAX_NB'(be_eff)));

    always_ff @(posedge clk) begin
        if (gate_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/scm_mp_mem.sv
// -----------------------------------------------------------------------------
// scm_mp_mem : standard-cell memory, 1 byte-masked write port,
//              NUM_RD independent registered read ports.
//
// Ports
//   clk   clock, all state on the rising edge
//   rst   asynchronous active-high reset (clears dout/dvalid only)
//   bus   scm_mp_mem_if.slave: se, we, waddr, wbe, din, re, raddr in;
//         dout, dvalid out
//
// Behaviour
//   Write lands on the edge where we=1 and waddr<NUM_ROWS; out-of-range
//   writes and writes on an edge with rst asserted are dropped.
//   Read: one cycle latency, dout holds until the next read on that port,
//   dvalid pulses for one cycle per read. Out-of-range reads return zero.
//   Same-row read and write in one cycle returns the old row contents.
//
// Optional feature
//   SCM_WR_BYPASS_EN : same-cycle same-address reads return the written
//   bytes merged over the old row (write-through). Without it there is no
//   din->dout path.
// -----------------------------------------------------------------------------
module scm_mp_mem
    import scm_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_ROWS   = 64,
    parameter int NUM_RD     = 2
) (
    input  logic         clk,
    input  logic         rst,
    scm_mp_mem_if.slave  bus
);

    logic [DATA_WIDTH-1:0]                row_q [NUM_ROWS];
    logic [NUM_ROWS-1:0]                  row_wr;
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    rd_addr;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd_data;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]    dout_q;
    logic [NUM_RD-1:0]                    dvalid_q;

    // Row write decode. Out-of-range addresses match no row, and an edge
    // with reset asserted must not disturb the array.
    always_comb begin
        row_wr = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            row_wr[r] = bus.we & ~rst & (bus.waddr == ADDR_WIDTH'(r));
        end
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        scm_row #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_row (
            .clk   (clk),
            .se    (bus.se),
            .wr_en (row_wr[r]),
            .wbe   (bus.wbe),
            .din   (bus.din),
            .q     (row_q[r])
        );
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_addr[p] = bus.raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Read muxes: an AND-OR select over the rows, so an address with no
    // implemented row falls through to zero.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data[p] = '0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (rd_addr[p] == ADDR_WIDTH'(r)) begin
                    rd_data[p] = row_q[r];
                end
            end
`ifdef SCM_WR_BYPASS_EN
            // Write-through: overlay the bytes being written this edge.
            if (bus.we && (rd_addr[p] == bus.waddr) &&
                addr_in_range(32'(rd_addr[p]), NUM_ROWS)) begin
                rd_data[p] = DATA_WIDTH'(merge(MAX_DW'(rd_data[p]), MAX_DW'(bus.din),
                                               MAX_NB'(bus.wbe)));
            end
`endif
        end
    end

    // Output registers: data holds between reads, valid is a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q   <= '0;
            dvalid_q <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                if (bus.re[p]) begin
                    dout_q[p]   <= rd_data[p];
                    dvalid_q[p] <= 1'b1;
                end else begin
                    dvalid_q[p] <= 1'b0;
                end
            end
        end
    end

    assign bus.dout   = dout_q;
    assign bus.dvalid = dvalid_q;

endmodule

// File: tb/tb_scm_mp_mem.sv
// -----------------------------------------------------------------------------
// tb_scm_mp_mem : directed + randomized bench for scm_mp_mem
// (64-bit rows, 6 address bits, 48 rows, 2 read ports).
// A behavioural memory model predicts dout/dvalid for every clock edge.
// Honours SCM_WR_BYPASS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_scm_mp_mem;

    localparam int DW   = 64;
    localparam int AW   = 6;
    localparam int ROWS = 48;
    localparam int NRD  = 2;
    localparam int NB   = DW / 8;

    logic clk;
    logic rst;

    scm_mp_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NRD)) bus ();

    scm_mp_mem #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_ROWS   (ROWS),
        .NUM_RD     (NRD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] ref_mem [ROWS];
    logic [DW-1:0] exp_dout [NRD];
    logic          exp_vld  [NRD];
    int checks = 0;
    int errors = 0;

    function automatic logic [DW-1:0] byte_overlay(input logic [DW-1:0] old_w,
                                                   input logic [DW-1:0] new_w,
                                                   input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < NB; b++)
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    // What one rising edge does, from the observable rules.
    task automatic model_edge();
        int a;
        logic [DW-1:0] v;
        if (rst) begin
            for (int p = 0; p < NRD; p++) begin
                exp_dout[p] = '0;
                exp_vld[p]  = 1'b0;
            end
            return;
        end
        for (int p = 0; p < NRD; p++) begin
            if (bus.re[p]) begin
                a = int'(bus.raddr[p*AW +: AW]);
                v = (a < ROWS) ? ref_mem[a] : '0;
`ifdef SCM_WR_BYPASS_EN
                if (bus.we && a == int'(bus.waddr) && a < ROWS)
                    v = byte_overlay(v, bus.din, bus.wbe);
`endif
                exp_dout[p] = v;
                exp_vld[p]  = 1'b1;
            end else begin
                exp_vld[p]  = 1'b0;
            end
        end
        if (bus.we && int'(bus.waddr) < ROWS)
            ref_mem[bus.waddr] = byte_overlay(ref_mem[bus.waddr], bus.din, bus.wbe);
    endtask

    task automatic check_outputs(input string tag);
        for (int p = 0; p < NRD; p++) begin
            checks++;
            assert (bus.dout[p*DW +: DW] === exp_dout[p]) else begin
                errors++;
                $error("FAIL %s dout%0d observed %h expected %h", tag, p, bus.dout[p*DW +: DW], exp_dout[p]);
            end
            checks++;
            assert (bus.dvalid[p] === exp_vld[p]) else begin
                errors++;
                $error("FAIL %s dvalid%0d observed %b expected %b", tag, p, bus.dvalid[p], exp_vld[p]);
            end
        end
    endtask

    task automatic check_const(input string tag, input int p, input logic [DW-1:0] want);
        checks++;
        assert (bus.dout[p*DW +: DW] === want) else begin
            errors++;
            $error("FAIL %s dout%0d observed %h expected %h", tag, p, bus.dout[p*DW +: DW], want);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic idle();
        bus.se = 1'b0;
        bus.we = 1'b0;
        bus.re = '0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [NB-1:0] be, input string tag);
        idle();
        bus.we    = 1'b1;
        bus.waddr = AW'(a);
        bus.din   = d;
        bus.wbe   = be;
        cycle(tag);
    endtask

    task automatic rd(input int a0, input int a1, input string tag);
        idle();
        bus.re    = 2'b11;
        bus.raddr = {AW'(a1), AW'(a0)};
        cycle(tag);
    endtask

    int perm0 [ROWS];
    int perm1 [ROWS];

    initial begin
        int j, t;
        // ---- reset held with reads requested ----
        rst       = 1'b1;
        idle();
        bus.re    = 2'b11;
        bus.raddr = {AW'(20), AW'(7)};
        bus.waddr = '0;
        bus.wbe   = '0;
        bus.din   = '0;
        for (int p = 0; p < NRD; p++) begin
            exp_dout[p] = '0;
            exp_vld[p]  = 1'b0;
        end
        #1;
        check_outputs("reset_t0");
        for (int i = 0; i < 3; i++) cycle("reset_hold");
        rst = 1'b0;
        // first read after release: out-of-range rows, so data is a known zero
        rd(60, 63, "post_reset_read");
        idle();
        cycle("post_reset_idle");

        // ---- fill every row, read back in random order ----
        for (int r = 0; r < ROWS; r++) wr(r, {$urandom, $urandom}, 8'hFF, "fill");
        for (int i = 0; i < ROWS; i++) begin
            perm0[i] = i;
            perm1[i] = ROWS - 1 - i;
        end
        for (int i = ROWS - 1; i > 0; i--) begin
            j = int'($urandom_range(i, 0)); t = perm0[i]; perm0[i] = perm0[j]; perm0[j] = t;
            j = int'($urandom_range(i, 0)); t = perm1[i]; perm1[i] = perm1[j]; perm1[j] = t;
        end
        for (int i = 0; i < ROWS; i++) rd(perm0[i], perm1[i], "readback");
        idle();
        cycle("readback_end");

        // ---- partial byte write ----
        wr(5, 64'h1111_2222_3333_4444, 8'hFF, "row5_full");
        wr(5, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, "row5_partial");
        rd(5, 5, "row5_read");
        check_const("row5_merge", 0, 64'h1111_2222_CCCC_DDDD);
        check_const("row5_merge", 1, 64'h1111_2222_CCCC_DDDD);

        // ---- write with no byte enabled is a no-op ----
        wr(3, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, "wbe_zero");
        rd(3, 3, "wbe_zero_read");

        // ---- same-cycle read and write of one row ----
        wr(9, 64'h0, 8'hFF, "row9_clear");
        idle();
        bus.we    = 1'b1;
        bus.waddr = AW'(9);
        bus.din   = '1;
        bus.wbe   = 8'hFF;
        bus.re    = 2'b01;
        bus.raddr = {AW'(0), AW'(9)};
        cycle("rw_same_row");
`ifdef SCM_WR_BYPASS_EN
        check_const("rw_same_row_const", 0, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        check_const("rw_same_row_const", 0, 64'h0);
`endif
        rd(9, 9, "row9_after");
        check_const("row9_after_const", 0, 64'hFFFF_FFFF_FFFF_FFFF);

        // ---- out-of-range write and read ----
        wr(50, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, "oor_write");
        for (int r = 0; r < ROWS; r += 2) rd(r, r + 1, "oor_scan");
        rd(50, 50, "oor_read");
        check_const("oor_read_const", 0, 64'h0);

        // ---- scan enable with no write ----
        for (int i = 0; i < 20; i++) begin
            idle();
            bus.se    = 1'b1;
            bus.din   = {$urandom, $urandom};
            bus.waddr = AW'($urandom_range(ROWS - 1, 0));
            bus.wbe   = 8'hFF;
            cycle("se_open");
        end
        for (int r = 0; r < ROWS; r += 2) rd(r + 1, r, "se_scan");

        // ---- randomized traffic ----
        for (int i = 0; i < 300; i++) begin
            bus.se    = 1'($urandom_range(1, 0));
            bus.we    = 1'($urandom_range(1, 0));
            bus.waddr = AW'($urandom_range(63, 0));
            bus.wbe   = NB'($urandom);
            bus.din   = {$urandom, $urandom};
            bus.re    = NRD'($urandom_range(3, 0));
            bus.raddr = {AW'($urandom_range(63, 0)), AW'($urandom_range(63, 0))};
            if (i % 7 == 0) bus.raddr = {bus.waddr, bus.waddr};
            cycle("random");
        end

        // ---- asynchronous reset in the middle of a read ----
        rd(1, 2, "pre_pulse_read");
        #2;
        rst = 1'b1;
        #1;
        for (int p = 0; p < NRD; p++) begin
            exp_dout[p] = '0;
            exp_vld[p]  = 1'b0;
        end
        check_outputs("async_reset");
        idle();
        bus.we    = 1'b1;
        bus.waddr = AW'(1);
        bus.din   = 64'h0123_4567_89AB_CDEF;
        bus.wbe   = 8'hFF;
        bus.re    = 2'b11;
        cycle("reset_edge_write");
        rst = 1'b0;
        rd(1, 2, "after_pulse_read");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
